// File: rtl/i2c_slave_core_if.sv
// i2c_slave_core_if: bus pins and FIFO handshakes of the I2C slave core
//   enable_bit_i          slave participates when 1
//   scl_i / sda_i         asynchronous bus levels
//   sda_o                 0 pulls SDA low, 1 releases
//   rx_data_o/rx_valid_o  received byte and one-cycle push strobe
//   rev_fifo_full_i       receive FIFO full
//   tx_data_i             head of transmit FIFO
//   trans_fifo_empty_i    transmit FIFO empty
//   tx_read_o             one-cycle pop strobe
//   busy_o / rw_o         addressed flag and latched R/W bit
interface i2c_slave_core_if;
    logic       enable_bit_i;
    logic       scl_i;
    logic       sda_i;
    logic       sda_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rev_fifo_full_i;
    logic [7:0] tx_data_i;
    logic       trans_fifo_empty_i;
    logic       tx_read_o;
    logic       busy_o;
    logic       rw_o;
    modport slave (
        input  enable_bit_i, scl_i, sda_i, rev_fifo_full_i, tx_data_i, trans_fifo_empty_i,
        output sda_o, rx_data_o, rx_valid_o, tx_read_o, busy_o, rw_o
    );
    modport master (
        output enable_bit_i, scl_i, sda_i, rev_fifo_full_i, tx_data_i, trans_fifo_empty_i,
        input  sda_o, rx_data_o, rx_valid_o, tx_read_o, busy_o, rw_o
    );
endinterface

// File: rtl/i2c_slave_core.sv
// i2c_slave_core: byte-level I2C target with 7-bit address match and FIFO handshakes
//   i2c_core_clock_i  core clock
//   reset_bit_i       synchronous active-high reset
//   bus               i2c_slave_core_if.slave (bus pins, rx push, tx pop, status)
//   Optional glitch filter on SCL/SDA: define I2C_SLAVE_GLITCH_FILTER_EN
module i2c_slave_core #(
    parameter logic [6:0] SLAVE_ADDR   = 7'h55,
    parameter int         FILTER_DEPTH = 3
) (
    input logic             i2c_core_clock_i,
    input logic             reset_bit_i,
    i2c_slave_core_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP} state_t;
    state_t     state_q, state_d;
    // bit 0 = SCL, bit 1 = SDA
    logic [1:0] sync_a, sync_b, lvl, lvl_q;
    logic       scl, sda, scl_p, sda_p, rise, fall, start, stop, addr_hit, load;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] shreg_q, shreg_d, rx_data_q, rx_data_d;
    logic       sda_q, sda_d, rx_valid_q, rx_valid_d, tx_read_q, tx_read_d;
    logic       busy_q, busy_d, rw_q, rw_d;
    always_ff @(posedge i2c_core_clock_i) begin
        if (reset_bit_i) begin
            sync_a <= 2'b11;
            sync_b <= 2'b11;
            lvl_q  <= 2'b11;
        end else begin
            sync_a <= {bus.sda_i, bus.scl_i};
            sync_b <= sync_a;
            lvl_q  <= lvl;
        end
    end
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    localparam int CW = $clog2(FILTER_DEPTH + 1);
    logic [CW-1:0] fcnt [2];
    // a new level is accepted only after FILTER_DEPTH consecutive samples of it
    always_ff @(posedge i2c_core_clock_i) begin
        if (reset_bit_i) begin
            lvl  <= 2'b11;
            fcnt <= '{default: '0};
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync_b[i] == lvl[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == CW'(FILTER_DEPTH - 1)) begin
                    lvl[i]  <= sync_b[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + 1'b1;
                end
            end
        end
    end
`else
    logic unused_filter_depth;
    assign unused_filter_depth = FILTER_DEPTH != 0;
    assign lvl = sync_b;
`endif
    assign scl      = lvl[0];
    assign sda      = lvl[1];
    assign scl_p    = lvl_q[0];
    assign sda_p    = lvl_q[1];
    assign rise     = scl & ~scl_p;
    assign fall     = ~scl & scl_p;
    // SCL must be stable high, so START/STOP never coincide with a data sample
    assign start    = scl & scl_p & ~sda & sda_p;
    assign stop     = scl & scl_p & sda & ~sda_p;
    assign addr_hit = shreg_q[6:0] == SLAVE_ADDR;
    always_ff @(posedge i2c_core_clock_i) begin
        if (reset_bit_i) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            shreg_q    <= 8'h00;
            sda_q      <= 1'b1;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            tx_read_q  <= 1'b0;
            busy_q     <= 1'b0;
            rw_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            sda_q      <= sda_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_read_q  <= tx_read_d;
            busy_q     <= busy_d;
            rw_q       <= rw_d;
        end
    end
    // ACK slots: cnt 8 = waiting for the fall that starts the drive, 9 = driving
    always_comb begin
        state_d = state_q;
        if (!bus.enable_bit_i) begin
            state_d = IDLE;
        end else if (start) begin
            state_d = ADDR;
        end else if (stop) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                ADDR:     if (rise && cnt_q == 4'd7) state_d = addr_hit ? ADDR_ACK : WAIT_STOP;
                ADDR_ACK: if (fall && cnt_q == 4'd9) state_d = rw_q ? RD_DATA : WR_DATA;
                WR_DATA:  if (rise && cnt_q == 4'd7) state_d = bus.rev_fifo_full_i ? WAIT_STOP : WR_ACK;
                WR_ACK:   if (fall && cnt_q == 4'd9) state_d = WR_DATA;
                RD_DATA:  if (fall && cnt_q == 4'd7) state_d = RD_ACK;
                RD_ACK:   state_d = (rise && sda) ? WAIT_STOP : (fall && cnt_q == 4'd9) ? RD_DATA : RD_ACK;
                default:  state_d = state_q;
            endcase
        end
    end
    always_comb begin
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        sda_d      = sda_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_read_d  = 1'b0;
        busy_d     = busy_q;
        rw_d       = rw_q;
        load       = 1'b0;
        if (!bus.enable_bit_i || start || stop) begin
            sda_d  = 1'b1;
            busy_d = 1'b0;
            cnt_d  = 4'd0;
        end else begin
            case (state_q)
                ADDR: if (rise) begin
                    shreg_d = {shreg_q[6:0], sda};
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd7 && addr_hit) begin
                        rw_d   = sda;
                        busy_d = 1'b1;
                    end
                end
                ADDR_ACK, WR_ACK: if (fall) begin
                    cnt_d = (cnt_q == 4'd8) ? 4'd9 : 4'd0;
                    sda_d = cnt_q != 4'd8;
                    load  = cnt_q == 4'd9 && state_q == ADDR_ACK && rw_q;
                end
                WR_DATA: if (rise) begin
                    shreg_d = {shreg_q[6:0], sda};
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd7 && !bus.rev_fifo_full_i) begin
                        rx_data_d  = {shreg_q[6:0], sda};
                        rx_valid_d = 1'b1;
                    end
                end
                // after the 8th bit the line is released for the master's ACK
                RD_DATA: if (fall) begin
                    cnt_d   = cnt_q + 4'd1;
                    shreg_d = {shreg_q[6:0], 1'b1};
                    sda_d   = (cnt_q == 4'd7) | shreg_q[6];
                end
                RD_ACK: begin
                    if (rise && !sda) cnt_d = 4'd9;
                    load = fall && cnt_q == 4'd9;
                end
                default: sda_d = 1'b1;
            endcase
            if (load) begin
                shreg_d   = bus.trans_fifo_empty_i ? 8'hFF : bus.tx_data_i;
                sda_d     = bus.trans_fifo_empty_i | bus.tx_data_i[7];
                tx_read_d = !bus.trans_fifo_empty_i;
                cnt_d     = 4'd0;
            end
        end
    end
    assign bus.sda_o      = sda_q;
    assign bus.rx_data_o  = rx_data_q;
    assign bus.rx_valid_o = rx_valid_q;
    assign bus.tx_read_o  = tx_read_q;
    assign bus.busy_o     = busy_q;
    assign bus.rw_o       = rw_q;
endmodule

// File: tb/tb_i2c_slave_core.sv
// tb_i2c_slave_core: directed bus-level bench for i2c_slave_core
module tb_i2c_slave_core;
    localparam int H = 6;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic m_sda = 1'b1;
    int n_checks = 0;
    int n_fail = 0;
    int rx_cnt = 0;
    int tx_cnt = 0;
    int low_cnt = 0;
    int both_cnt = 0;
    logic [7:0] rx_last = 8'h00;
    i2c_slave_core_if bus();
    assign bus.sda_i = m_sda & bus.sda_o;
    i2c_slave_core dut (.i2c_core_clock_i(clk), .reset_bit_i(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rx_valid_o) begin
                rx_cnt++;
                rx_last = bus.rx_data_o;
            end
            if (bus.tx_read_o) tx_cnt++;
            if (!bus.sda_o) low_cnt++;
            if (bus.rx_valid_o && bus.tx_read_o) both_cnt++;
        end
    end
    task automatic w(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic clock_bit(input logic b, input logic glitch, output logic seen);
        m_sda = b;
        w(H);
        bus.scl_i = 1'b1;
        if (glitch) begin
            w(3);
            bus.scl_i = 1'b0;
            w(1);
            bus.scl_i = 1'b1;
            w(H - 4);
        end else begin
            w(H);
        end
        seen = bus.sda_i;
        w(H);
        bus.scl_i = 1'b0;
        w(H);
    endtask
    task automatic i2c_start;
        m_sda = 1'b1;
        w(H);
        bus.scl_i = 1'b1;
        w(2 * H);
        m_sda = 1'b0;
        w(2 * H);
        bus.scl_i = 1'b0;
        w(H);
    endtask
    task automatic i2c_stop;
        m_sda = 1'b0;
        w(H);
        bus.scl_i = 1'b1;
        w(2 * H);
        m_sda = 1'b1;
        w(2 * H);
    endtask
    task automatic send_byte(input logic [7:0] d, input int gbit, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(d[i], i == gbit, s);
        clock_bit(1'b1, 1'b0, ack);
    endtask
    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, 1'b0, s);
            d[i] = s;
        end
        clock_bit(mack, 1'b0, s);
    endtask
    task automatic test_reset;
        rst = 1'b1;
        w(3);
        rst = 1'b0;
        w(2);
        n_checks++; if (bus.sda_o !== 1'b1) begin n_fail++; $display("FAIL reset_sda: got %b expected 1", bus.sda_o); end
        n_checks++; if (bus.rx_data_o !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h expected 00", bus.rx_data_o); end
        n_checks++; if (bus.rx_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b expected 0", bus.rx_valid_o); end
        n_checks++; if (bus.tx_read_o !== 1'b0) begin n_fail++; $display("FAIL reset_tx_read: got %b expected 0", bus.tx_read_o); end
        n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy_o); end
        n_checks++; if (bus.rw_o !== 1'b0) begin n_fail++; $display("FAIL reset_rw: got %b expected 0", bus.rw_o); end
    endtask
    task automatic test_write;
        logic a;
        int rx0 = rx_cnt;
        i2c_start;
        send_byte(8'hAA, -1, a);
        n_checks++; if (a !== 1'b0) begin n_fail++; $display("FAIL write_addr_ack: got %b expected 0", a); end
        n_checks++; if (bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL write_busy: got %b expected 1", bus.busy_o); end
        n_checks++; if (bus.rw_o !== 1'b0) begin n_fail++; $display("FAIL write_rw: got %b expected 0", bus.rw_o); end
        send_byte(8'hA5, -1, a);
        n_checks++; if (a !== 1'b0) begin n_fail++; $display("FAIL write_data_ack: got %b expected 0", a); end
        n_checks++; if (rx_cnt - rx0 !== 1) begin n_fail++; $display("FAIL write_rx_count: got %0d expected 1", rx_cnt - rx0); end
        n_checks++; if (rx_last !== 8'hA5) begin n_fail++; $display("FAIL write_rx_data: got %h expected a5", rx_last); end
        i2c_stop;
        n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL write_busy_stop: got %b expected 0", bus.busy_o); end
    endtask
    task automatic test_mismatch;
        logic a1, a2;
        int rx0 = rx_cnt;
        int tx0 = tx_cnt;
        int lo0 = low_cnt;
        i2c_start;
        send_byte(8'h22, -1, a1);
        send_byte(8'h11, -1, a2);
        n_checks++; if (a1 !== 1'b1 || a2 !== 1'b1) begin n_fail++; $display("FAIL mismatch_ack: got %b%b expected 11", a1, a2); end
        n_checks++; if (low_cnt - lo0 !== 0) begin n_fail++; $display("FAIL mismatch_sda_low: got %0d cycles expected 0", low_cnt - lo0); end
        n_checks++; if (rx_cnt - rx0 !== 0 || tx_cnt - tx0 !== 0) begin n_fail++; $display("FAIL mismatch_strobes: got rx %0d tx %0d expected 0 0", rx_cnt - rx0, tx_cnt - tx0); end
        n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL mismatch_busy: got %b expected 0", bus.busy_o); end
        i2c_stop;
    endtask
    task automatic test_read;
        logic a;
        logic [7:0] d;
        int tx0 = tx_cnt;
        bus.tx_data_i = 8'h3C;
        bus.trans_fifo_empty_i = 1'b0;
        i2c_start;
        send_byte(8'hAB, -1, a);
        w(4);
        bus.trans_fifo_empty_i = 1'b1;
        n_checks++; if (a !== 1'b0 || bus.rw_o !== 1'b1) begin n_fail++; $display("FAIL read_addr: got ack %b rw %b expected 0 1", a, bus.rw_o); end
        read_byte(1'b0, d);
        n_checks++; if (d !== 8'h3C) begin n_fail++; $display("FAIL read_byte0: got %h expected 3c", d); end
        read_byte(1'b1, d);
        n_checks++; if (d !== 8'hFF) begin n_fail++; $display("FAIL read_byte1_empty: got %h expected ff", d); end
        n_checks++; if (tx_cnt - tx0 !== 1) begin n_fail++; $display("FAIL read_pops: got %0d expected 1", tx_cnt - tx0); end
        bus.tx_data_i = 8'h00;
        bus.trans_fifo_empty_i = 1'b0;
        read_byte(1'b0, d);
        read_byte(1'b0, d);
        n_checks++; if (d !== 8'hFF || tx_cnt - tx0 !== 1) begin n_fail++; $display("FAIL read_wait_stop: got %h pops %0d expected ff 1", d, tx_cnt - tx0); end
        i2c_stop;
        bus.trans_fifo_empty_i = 1'b1;
        n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL read_busy_stop: got %b expected 0", bus.busy_o); end
    endtask
    task automatic test_rx_full;
        logic a;
        int rx0 = rx_cnt;
        i2c_start;
        send_byte(8'hAA, -1, a);
        bus.rev_fifo_full_i = 1'b1;
        send_byte(8'h5A, -1, a);
        n_checks++; if (a !== 1'b1) begin n_fail++; $display("FAIL full_nack: got %b expected 1", a); end
        bus.rev_fifo_full_i = 1'b0;
        send_byte(8'h33, -1, a);
        n_checks++; if (a !== 1'b1) begin n_fail++; $display("FAIL full_ignored_ack: got %b expected 1", a); end
        n_checks++; if (rx_cnt - rx0 !== 0) begin n_fail++; $display("FAIL full_rx_count: got %0d expected 0", rx_cnt - rx0); end
        i2c_stop;
    endtask
    task automatic test_repeated_start;
        logic a;
        logic [7:0] d;
        i2c_start;
        send_byte(8'hAA, -1, a);
        send_byte(8'h01, -1, a);
        n_checks++; if (bus.rw_o !== 1'b0 || a !== 1'b0) begin n_fail++; $display("FAIL rstart_write: got rw %b ack %b expected 0 0", bus.rw_o, a); end
        i2c_start;
        send_byte(8'hAB, -1, a);
        n_checks++; if (bus.rw_o !== 1'b1 || a !== 1'b0 || bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL rstart_read: got rw %b ack %b busy %b expected 1 0 1", bus.rw_o, a, bus.busy_o); end
        read_byte(1'b1, d);
        n_checks++; if (d !== 8'hFF) begin n_fail++; $display("FAIL rstart_byte: got %h expected ff", d); end
        n_checks++; if (bus.rx_data_o !== 8'h01 || rx_last !== 8'h01) begin n_fail++; $display("FAIL rstart_rx_data: got %h expected 01", bus.rx_data_o); end
        i2c_stop;
    endtask
    task automatic test_glitch;
        logic a;
        logic ea;
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
        ea = 1'b0;
`else
        ea = 1'b1;
`endif
        i2c_start;
        send_byte(8'hAA, 7, a);
        w(4);
        n_checks++; if (a !== ea) begin n_fail++; $display("FAIL glitch_ack: got %b expected %b", a, ea); end
        n_checks++; if (bus.busy_o !== ~ea) begin n_fail++; $display("FAIL glitch_busy: got %b expected %b", bus.busy_o, ~ea); end
        i2c_stop;
    endtask
    task automatic test_reset_mid_byte;
        logic a;
        bus.tx_data_i = 8'h00;
        bus.trans_fifo_empty_i = 1'b0;
        i2c_start;
        send_byte(8'hAB, -1, a);
        w(4);
        n_checks++; if (bus.sda_o !== 1'b0 || bus.busy_o !== 1'b1 || bus.rw_o !== 1'b1) begin n_fail++; $display("FAIL mid_state: got sda %b busy %b rw %b expected 0 1 1", bus.sda_o, bus.busy_o, bus.rw_o); end
        rst = 1'b1;
        w(1);
        n_checks++; if (bus.sda_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.rw_o !== 1'b0) begin n_fail++; $display("FAIL mid_reset_ctrl: got sda %b busy %b rw %b expected 1 0 0", bus.sda_o, bus.busy_o, bus.rw_o); end
        n_checks++; if (bus.rx_data_o !== 8'h00 || bus.rx_valid_o !== 1'b0 || bus.tx_read_o !== 1'b0) begin n_fail++; $display("FAIL mid_reset_data: got rx %h valid %b pop %b expected 00 0 0", bus.rx_data_o, bus.rx_valid_o, bus.tx_read_o); end
        rst = 1'b0;
        bus.trans_fifo_empty_i = 1'b1;
        bus.scl_i = 1'b1;
        w(H);
        m_sda = 1'b1;
        w(H);
    endtask
    initial begin
        bus.enable_bit_i = 1'b1;
        bus.scl_i = 1'b1;
        bus.rev_fifo_full_i = 1'b0;
        bus.tx_data_i = 8'h00;
        bus.trans_fifo_empty_i = 1'b1;
        test_reset;
        test_write;
        test_mismatch;
        test_read;
        test_rx_full;
        test_repeated_start;
        test_glitch;
        test_reset_mid_byte;
        n_checks++; if (both_cnt !== 0) begin n_fail++; $display("FAIL strobe_overlap: got %0d cycles expected 0", both_cnt); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/i2c_slave_core.md
# i2c_slave_core

Byte-level I2C slave (target) engine. It is the responder counterpart to the team's I2C master and runs on the same core clock. It oversamples `scl_i`/`sda_i`, detects START, repeated START and STOP, matches a 7-bit address, and moves bytes to the receive FIFO (master writes) or from the transmit FIFO (master reads). It drives SDA open-drain style and never drives SCL.

## Interface
Parameters:
- `SLAVE_ADDR`, 7'h55, own 7-bit address
- `FILTER_DEPTH`, 3, consecutive equal samples needed to accept a new SCL/SDA level (used only with the filter macro)

Ports:
- `i2c_core_clock_i`  in  1  core clock; all logic rises on it
- `reset_bit_i`  in  1  reset, synchronous, active-high
- `enable_bit_i`  in  1  1 = slave participates; 0 = forced to IDLE, SDA released
- `scl_i`  in  1  bus SCL (asynchronous)
- `sda_i`  in  1  bus SDA (asynchronous)
- `sda_o`  out  1  0 = pull SDA low, 1 = release; reset 1
- `rx_data_o`  out  8  received byte; reset 8'h00
- `rx_valid_o`  out  1  one-cycle push strobe for `rx_data_o`; reset 0
- `rev_fifo_full_i`  in  1  receive FIFO full
- `tx_data_i`  in  8  head of transmit FIFO
- `trans_fifo_empty_i`  in  1  transmit FIFO empty
- `tx_read_o`  out  1  one-cycle pop strobe; reset 0
- `busy_o`  out  1  1 from address match until STOP, START or disable; reset 0
- `rw_o`  out  1  latched R/W bit of the matched address byte; reset 0

## Operation
- **Input path:**
  - `scl_i`/`sda_i` pass through 2-flop synchronizers, then one registered copy for edge detection.
  - SCL rise/fall = synced value differs from its registered copy.
- **Bus conditions:**
  - START = SDA falling while SCL high.
  - STOP = SDA rising while SCL high.
  - Both are evaluated in every state, including while the slave drives SDA.
- **States:** IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
- **START (any state):** go to ADDR, clear the bit counter, set `sda_o`=1.
- **STOP (any state):** go to IDLE, set `sda_o`=1, `busy_o`=0.
- **ADDR:**
  - Shift SDA in on each SCL rise, MSB first, 8 bits.
  - If bits[7:1]==`SLAVE_ADDR`: latch `rw_o`=bit0, set `busy_o`=1, go to ADDR_ACK.
  - Otherwise go to WAIT_STOP and never drive SDA.
- **ADDR_ACK:**
  - On the SCL fall after the 8th rise, `sda_o`=0.
  - On the next SCL fall (end of the 9th clock), release SDA.
  - Then go to RD_DATA if `rw_o`=1, else WR_DATA.
  - Entering RD_DATA loads the first byte (see read rule).
- **WR_DATA:**
  - Shift 8 bits on SCL rises.
  - At the 8th rise: if `rev_fifo_full_i`=0, present `rx_data_o` with `rx_valid_o`=1 for one cycle, then ACK.
  - If full: no strobe, byte dropped, NACK (SDA released), then go to WAIT_STOP.
- **WR_ACK:** drive ACK over the 9th clock exactly as in ADDR_ACK, then return to WR_DATA.
- **Read byte load:**
  - At each byte start (SCL fall ending the ACK slot), if `trans_fifo_empty_i`=0: load `tx_data_i` and pulse `tx_read_o` in the same cycle.
  - If empty: load 8'hFF, no pop.
- **RD_DATA:**
  - Put the shift register MSB on `sda_o` (0 drives, 1 releases).
  - Advance one bit on each SCL fall; 8 bits per byte.
- **RD_ACK:**
  - Release SDA and sample the master's bit on the 9th SCL rise.
  - 0 → RD_DATA with the next byte loaded.
  - 1 (NACK) → WAIT_STOP.
- **WAIT_STOP:** SDA released; leaves only on START or STOP.
- **Disable:** `enable_bit_i`=0 forces IDLE with `sda_o`=1, `busy_o`=0, no strobes, and has priority over bus events.
- **Reset:** `reset_bit_i`=1 forces every output to its reset value on the next clock edge, including mid-byte, and has priority over everything.

## Timing
- Pin-to-event latency: 3 core cycles (2 sync + edge register); with filter, add `FILTER_DEPTH`.
- `sda_o` update: 1 cycle after the detected SCL fall.
- `rx_valid_o`: 1 cycle after the detected 8th SCL rise.
- `tx_read_o` and shift-register load: same cycle.
- Bus requirement: SCL high and low phases ≥ 8 core cycles (≥ 8+`FILTER_DEPTH` with filter), so that data is stable before the master's next rise.
- `rx_valid_o` and `tx_read_o` are never asserted in the same cycle, and each lasts exactly 1 cycle.
- START and data sampling never coincide: START requires SCL high with no SCL edge in the same cycle.

## Configuration
- Macro: `I2C_SLAVE_GLITCH_FILTER_EN`.
- Defined: each synced line passes a counter filter, and the filtered level changes only after `FILTER_DEPTH` consecutive equal samples. Pulses shorter than that are ignored.
- Undefined: no filter; edges are taken directly from the synchronizer output, and `FILTER_DEPTH` is unused.

## Test plan
- Write: START, 0xAA (addr 0x55, W), 0xA5, STOP → `sda_o`=0 in both ACK slots; one `rx_valid_o` with `rx_data_o`=0xA5; `busy_o` 1→0 at STOP.
- Mismatch: START, 0x22, 0x11, STOP → `sda_o` stays 1 throughout; no strobes; `busy_o`=0.
- Read: `tx_data_i`=0x3C then empty; START, 0xAB, master ACK then NACK → bytes 0x3C then 0xFF on SDA; exactly one `tx_read_o`; WAIT_STOP reached.
- RX full: `rev_fifo_full_i`=1 during the write of byte 0x5A → NACK on the 9th clock; no `rx_valid_o`; slave ignores further bytes until the next START.
- Repeated START: write 0xAA + 0x01, then START, 0xAB, read one byte → `rw_o` switches 0→1 without passing IDLE; `rx_data_o`=0x01.
- Glitch/reset: 1-cycle SCL low pulse mid-address → ignored with the macro, one extra bit counted without it. Asserting `reset_bit_i` mid-byte → all outputs return to reset values next cycle.
